// File: rtl/ws2812_stream_ctl_pkg.sv
// ws2812_pkg: opcodes, stream FSM states and pixel modes shared by the stream controller
package ws2812_pkg;
  localparam logic [7:0] CMD_SET_CHAN  = 8'h2A;
  localparam logic [7:0] CMD_SET_ADDR  = 8'h2B;
  localparam logic [7:0] CMD_WRITE     = 8'h2C;
  localparam logic [7:0] CMD_SET_MODE  = 8'h2D;
  localparam logic [7:0] CMD_BROADCAST = 8'h2E;
  localparam logic [7:0] CMD_COMMIT    = 8'h2F;
  typedef enum logic [2:0] {ST_IDLE, ST_ARG_CHAN, ST_ARG_ADDR, ST_ARG_MODE, ST_WRITE} stream_state_t;
  typedef enum logic {MODE_RGB, MODE_RGBW} pixel_mode_t;
endpackage

// File: rtl/ws2812_stream_ctl_if.sv
// ws2812_stream_ctl_if: byte stream in (dc/rdy/data) and pixel-buffer write/commit/error out
// master = byte source and buffer side, slave = the stream controller
interface ws2812_stream_ctl_if #(
  parameter int CHANNELS = 8,
  parameter int PIXELS   = 64
);
  localparam int ADDR_W = $clog2(PIXELS);
  logic                dc_in;
  logic                byte_rdy_in;
  logic [7:0]          byte_data_in;
  logic [CHANNELS-1:0] wr_en_out;
  logic [ADDR_W-1:0]   wr_addr_out;
  logic [3:0]          byte_en_out;
  logic [7:0]          byte_data_out;
  logic                rgbw_mode_out;
  logic                frame_rdy_out;
  logic                err_out;
  modport master (
    output dc_in, byte_rdy_in, byte_data_in,
    input  wr_en_out, wr_addr_out, byte_en_out, byte_data_out, rgbw_mode_out, frame_rdy_out, err_out
  );
  modport slave (
    input  dc_in, byte_rdy_in, byte_data_in,
    output wr_en_out, wr_addr_out, byte_en_out, byte_data_out, rgbw_mode_out, frame_rdy_out, err_out
  );
endinterface

// File: rtl/ws2812_stream_ctl_cmd_dec.sv
// ws2812_cmd_dec: command byte -> next stream state plus unknown-opcode flag
// i_byte: command byte; o_state: state entered; o_unknown: opcode not recognised
module ws2812_cmd_dec import ws2812_pkg::*; (
  input  logic [7:0]    i_byte,
  output stream_state_t o_state,
  output logic          o_unknown
);
  always_comb begin
    o_state   = ST_IDLE;
    o_unknown = 1'b0;
    case (i_byte)
      CMD_SET_CHAN:             o_state = ST_ARG_CHAN;
      CMD_SET_ADDR:             o_state = ST_ARG_ADDR;
      CMD_SET_MODE:             o_state = ST_ARG_MODE;
      CMD_WRITE, CMD_BROADCAST: o_state = ST_WRITE;
      CMD_COMMIT:               o_state = ST_IDLE;
      default:                  o_unknown = 1'b1;
    endcase
  end
endmodule

// File: rtl/ws2812_stream_ctl.sv
// ws2812_stream_ctl: decodes the SPI command/data byte stream into per-channel pixel buffer writes
// clk_in/rst_in: clock and async active-high reset; bus: byte stream in, write strobes/commit/error out
module ws2812_stream_ctl import ws2812_pkg::*; #(
  parameter  int CHANNELS = 8,
  parameter  int PIXELS   = 64,
  localparam int CH_W     = $clog2(CHANNELS),
  localparam int ADDR_W   = $clog2(PIXELS)
) (
  input logic clk_in,
  input logic rst_in,
  ws2812_stream_ctl_if.slave bus
);
  stream_state_t       r_state, w_dec_state;
  pixel_mode_t         r_mode;
  logic                w_unknown;
  logic                r_bcast;
  logic [CH_W-1:0]     r_chan;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_lane;
  logic [CHANNELS-1:0] r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [3:0]          r_byte_en;
  logic [7:0]          r_byte_data;
  logic                r_frame_rdy;
  logic                r_err;
  logic                w_cmd, w_dat, w_last_lane, w_addr_wrap, w_chan_wrap, w_chan_ok, w_addr_ok;
  ws2812_cmd_dec u_dec (.i_byte(bus.byte_data_in), .o_state(w_dec_state), .o_unknown(w_unknown));
  assign w_cmd       = bus.byte_rdy_in & ~bus.dc_in;
  assign w_dat       = bus.byte_rdy_in &  bus.dc_in;
  assign w_last_lane = r_lane == ((r_mode == MODE_RGBW) ? 2'd3 : 2'd2);
  assign w_addr_wrap = r_addr == ADDR_W'(PIXELS - 1);
  assign w_chan_wrap = r_chan == CH_W'(CHANNELS - 1);
  // 9-bit compares so CHANNELS/PIXELS = 256 never truncate to 0
  assign w_chan_ok   = {1'b0, bus.byte_data_in} < 9'(CHANNELS);
  assign w_addr_ok   = {1'b0, bus.byte_data_in} < 9'(PIXELS);
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_RGB;
      r_bcast     <= 1'b0;
      r_chan      <= '0;
      r_addr      <= '0;
      r_lane      <= '0;
      r_wr_en     <= '0;
      r_wr_addr   <= '0;
      r_byte_en   <= '0;
      r_byte_data <= '0;
      r_frame_rdy <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_wr_en     <= '0;
      r_frame_rdy <= 1'b0;
      if (w_cmd) begin
        r_lane  <= '0;
        r_state <= w_dec_state;
        r_bcast <= bus.byte_data_in == CMD_BROADCAST;
        if (w_unknown) r_err <= 1'b1;
        if (bus.byte_data_in == CMD_COMMIT) begin
          r_frame_rdy <= 1'b1;
          r_err       <= 1'b0;
          r_chan      <= '0;
          r_addr      <= '0;
        end
      end else if (w_dat) begin
        case (r_state)
          ST_ARG_CHAN: begin
            if (w_chan_ok) begin
              r_chan <= CH_W'(bus.byte_data_in);
              r_addr <= '0;
            end else r_err <= 1'b1;
            r_state <= ST_IDLE;
          end
          ST_ARG_ADDR: begin
            if (w_addr_ok) r_addr <= ADDR_W'(bus.byte_data_in);
            else r_err <= 1'b1;
            r_state <= ST_IDLE;
          end
          ST_ARG_MODE: begin
            r_mode  <= pixel_mode_t'(bus.byte_data_in[0]);
            r_lane  <= '0;
            r_state <= ST_IDLE;
          end
          ST_WRITE: begin
            r_wr_en     <= r_bcast ? '1 : CHANNELS'(1) << r_chan;
            r_wr_addr   <= r_addr;
            r_byte_en   <= 4'b0001 << r_lane;
            r_byte_data <= bus.byte_data_in;
            r_lane      <= w_last_lane ? 2'd0 : r_lane + 2'd1;
            if (w_last_lane) begin
              r_addr <= w_addr_wrap ? '0 : r_addr + ADDR_W'(1);
              // a single-channel stream spills onto the next channel once this one is full
              if (w_addr_wrap && !r_bcast) r_chan <= w_chan_wrap ? '0 : r_chan + CH_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end
  assign bus.wr_en_out     = r_wr_en;
  assign bus.wr_addr_out   = r_wr_addr;
  assign bus.byte_en_out   = r_byte_en;
  assign bus.byte_data_out = r_byte_data;
  assign bus.rgbw_mode_out = r_mode == MODE_RGBW;
  assign bus.frame_rdy_out = r_frame_rdy;
  assign bus.err_out       = r_err;
endmodule

// File: tb/tb_ws2812_stream_ctl.sv
// tb_ws2812_stream_ctl: directed checks of the stream controller on a 4-pixel and a 2-pixel instance
module tb_ws2812_stream_ctl;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   n_chk  = 0;
  int   n_err  = 0;
  always #5 clk_in = ~clk_in;
  ws2812_stream_ctl_if #(.CHANNELS(8), .PIXELS(4)) ia ();
  ws2812_stream_ctl_if #(.CHANNELS(8), .PIXELS(2)) ib ();
  ws2812_stream_ctl #(.CHANNELS(8), .PIXELS(4)) dut_a (.clk_in(clk_in), .rst_in(rst_in), .bus(ia.slave));
  ws2812_stream_ctl #(.CHANNELS(8), .PIXELS(2)) dut_b (.clk_in(clk_in), .rst_in(rst_in), .bus(ib.slave));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic dc, input logic [7:0] b);
    ia.dc_in = dc; ia.byte_data_in = b; ia.byte_rdy_in = 1'b1;
    ib.dc_in = dc; ib.byte_data_in = b; ib.byte_rdy_in = 1'b1;
    @(posedge clk_in); #1;
    ia.byte_rdy_in = 1'b0;
    ib.byte_rdy_in = 1'b0;
  endtask
  initial begin
    ia.dc_in = 1'b0; ia.byte_rdy_in = 1'b0; ia.byte_data_in = '0;
    ib.dc_in = 1'b0; ib.byte_rdy_in = 1'b0; ib.byte_data_in = '0;
    #12;
    chk("rst_we",    ia.wr_en_out, 0);
    chk("rst_addr",  ia.wr_addr_out, 0);
    chk("rst_be",    ia.byte_en_out, 0);
    chk("rst_data",  ia.byte_data_out, 0);
    chk("rst_mode",  ia.rgbw_mode_out, 0);
    chk("rst_frame", ia.frame_rdy_out, 0);
    chk("rst_err",   ia.err_out, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    send(1'b0, 8'h2C);
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 8'(8'h10 + i));
      chk("rgb_we",   ia.wr_en_out, 1);
      chk("rgb_addr", ia.wr_addr_out, i / 3);
      chk("rgb_be",   ia.byte_en_out, 1 << (i % 3));
      chk("rgb_data", ia.byte_data_out, 8'h10 + i);
    end
    @(posedge clk_in); #1;
    chk("idle_we",   ia.wr_en_out, 0);
    chk("idle_addr", ia.wr_addr_out, 1);
    chk("idle_be",   ia.byte_en_out, 4);
    send(1'b0, 8'h2F);
    chk("commit_frame", ia.frame_rdy_out, 1);
    @(posedge clk_in); #1;
    chk("commit_frame_low", ia.frame_rdy_out, 0);
    send(1'b0, 8'h2D);
    send(1'b1, 8'h01);
    chk("rgbw_mode", ia.rgbw_mode_out, 1);
    send(1'b0, 8'h2C);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 8'(8'h20 + i));
      chk("rgbw_we",   ia.wr_en_out, 1);
      chk("rgbw_addr", ia.wr_addr_out, 0);
      chk("rgbw_be",   ia.byte_en_out, 1 << i);
    end
    send(1'b0, 8'h2F);
    send(1'b0, 8'h2D);
    send(1'b1, 8'h00);
    chk("rgb_mode_back", ia.rgbw_mode_out, 0);
    send(1'b0, 8'h2A);
    send(1'b1, 8'h07);
    send(1'b0, 8'h2C);
    for (int i = 0; i < 12; i++) begin
      send(1'b1, 8'(8'h30 + i));
      chk("ch7_we",   ia.wr_en_out, 8'h80);
      chk("ch7_addr", ia.wr_addr_out, i / 3);
      chk("ch7_be",   ia.byte_en_out, 1 << (i % 3));
    end
    send(1'b1, 8'h3C);
    chk("chwrap_we",   ia.wr_en_out, 1);
    chk("chwrap_addr", ia.wr_addr_out, 0);
    chk("chwrap_be",   ia.byte_en_out, 1);
    send(1'b0, 8'h2F);
    send(1'b0, 8'h2E);
    for (int i = 0; i < 9; i++) begin
      send(1'b1, 8'(8'h40 + i));
      chk("bc_we_a",   ia.wr_en_out, 8'hFF);
      chk("bc_addr_a", ia.wr_addr_out, i / 3);
      chk("bc_we_b",   ib.wr_en_out, 8'hFF);
      chk("bc_addr_b", ib.wr_addr_out, (i / 3) % 2);
    end
    send(1'b0, 8'h2C);
    send(1'b1, 8'h50);
    chk("bc_chan_b", ib.wr_en_out, 1);
    send(1'b0, 8'h2F);
    send(1'b0, 8'h2A);
    send(1'b1, 8'h03);
    chk("err_clear", ia.err_out, 0);
    send(1'b0, 8'h2A);
    send(1'b1, 8'h08);
    chk("err_chan", ia.err_out, 1);
    @(posedge clk_in); #1;
    chk("err_sticky", ia.err_out, 1);
    send(1'b0, 8'h55);
    chk("err_op", ia.err_out, 1);
    send(1'b0, 8'h2C);
    send(1'b1, 8'h5A);
    chk("err_chan_kept", ia.wr_en_out, 8'h08);
    chk("err_addr",      ia.wr_addr_out, 0);
    chk("err_hold",      ia.err_out, 1);
    send(1'b0, 8'h2F);
    chk("err_commit_frame", ia.frame_rdy_out, 1);
    chk("err_commit_clr",   ia.err_out, 0);
    @(posedge clk_in); #1;
    chk("err_frame_low", ia.frame_rdy_out, 0);
    send(1'b0, 8'h2D);
    send(1'b1, 8'h01);
    send(1'b0, 8'h2B);
    send(1'b1, 8'h02);
    send(1'b0, 8'h2C);
    send(1'b1, 8'hAA);
    chk("pre_rst_addr", ia.wr_addr_out, 2);
    chk("pre_rst_be",   ia.byte_en_out, 1);
    chk("pre_rst_data", ia.byte_data_out, 8'hAA);
    chk("pre_rst_mode", ia.rgbw_mode_out, 1);
    #2 rst_in = 1'b1;
    #1;
    chk("arst_addr", ia.wr_addr_out, 0);
    chk("arst_be",   ia.byte_en_out, 0);
    chk("arst_data", ia.byte_data_out, 0);
    chk("arst_mode", ia.rgbw_mode_out, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    send(1'b0, 8'h2C);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 8'(8'h60 + i));
      chk("post_we",   ia.wr_en_out, 1);
      chk("post_addr", ia.wr_addr_out, 0);
      chk("post_be",   ia.byte_en_out, 1 << i);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ws2812_stream_ctl.md
# ws2812_stream_ctl

Parametrised command/data stream controller for the NeoPixel LED controller. It sits between the SPI slave byte stream and the per-channel pixel buffers, and generalises the fixed 8-layer, 64-pixel, RGB-only layer controller to N channels, P pixels, RGB/RGBW pixel formats and a broadcast mode. It decodes command bytes (`dc_in`=0) and argument/data bytes (`dc_in`=1) into buffer write strobes with auto-advancing addresses. It also produces a frame-commit pulse and a sticky error flag.

## Interface
- `CHANNELS`, 8: output channels; 2..256.
- `PIXELS`, 64: pixels per channel; 2..256.
- `CH_W`, `$clog2(CHANNELS)`: channel index width (derived).
- `ADDR_W`, `$clog2(PIXELS)`: pixel address width (derived).

Ports:
- `clk_in` in 1: system clock. One clock domain.
- `rst_in` in 1: reset, asynchronous, active-high.
- `dc_in` in 1: 0 = command byte, 1 = argument/data byte; sampled with `byte_rdy_in`.
- `byte_rdy_in` in 1: single-cycle strobe, byte valid.
- `byte_data_in` in 8: received byte.
- `wr_en_out` out CHANNELS: per-channel write strobe, 1 cycle.
- `wr_addr_out` out ADDR_W: pixel address of the write.
- `byte_en_out` out 4: one-hot byte lane within the pixel.
- `byte_data_out` out 8: registered copy of the data byte.
- `rgbw_mode_out` out 1: 0 = 3 bytes/pixel, 1 = 4 bytes/pixel.
- `frame_rdy_out` out 1: frame-commit pulse, 1 cycle.
- `err_out` out 1: sticky error flag.

## Operation
- Opcodes, accepted only when `dc_in`=0:
  - 0x2A SET_CHAN: takes 1 argument.
  - 0x2B SET_ADDR: takes 1 argument.
  - 0x2C WRITE: enters the data state on the selected channel.
  - 0x2D SET_MODE: takes 1 argument; bit0 = RGBW.
  - 0x2E BROADCAST_WRITE: enters the data state on all channels.
  - 0x2F COMMIT.
- States: IDLE, ARG_CHAN, ARG_ADDR, ARG_MODE, WRITE.
- Any command byte aborts the current state, clears the byte-lane index to 0, and is then decoded.
- IDLE: data bytes are ignored.
- Unknown opcode: go to IDLE, set `err_out`.
- ARG_CHAN:
  - Argument < CHANNELS: load the channel index, clear the address to 0.
  - Otherwise: set `err_out`, leave the index unchanged.
  - Either way, go to IDLE.
- ARG_ADDR:
  - Argument < PIXELS: load the address.
  - Otherwise: set `err_out`, leave the address unchanged.
  - Either way, go to IDLE.
- ARG_MODE: load bit0 into the mode, clear the lane index, go to IDLE.
- WRITE, per data byte:
  - `wr_en_out` = one-hot(channel), or all ones when broadcast.
  - `byte_en_out` = one-hot(lane).
  - Lane increments; it wraps at 3 in RGB mode and at 4 in RGBW mode.
- On the last lane, the address increments.
  - Address wraps at PIXELS-1 → 0.
  - Non-broadcast: the channel also advances, and CHANNELS-1 wraps to 0.
  - Broadcast: the channel is unchanged.
  - No error is raised on wrap.
- COMMIT: pulse `frame_rdy_out`, clear `err_out`, reset channel, address and lane to 0, go to IDLE. Mode is retained.
- Reset values: all outputs 0; mode RGB; channel 0; address 0; lane 0; state IDLE.

## Timing
- All outputs are registered. Latency is 1 cycle from the `byte_rdy_in` cycle to `wr_en_out`, `frame_rdy_out` or the `err_out` rise.
- `wr_addr_out`, `byte_en_out` and `byte_data_out` are valid in the `wr_en_out` cycle and hold until the next write.
- `wr_en_out` and `frame_rdy_out` are high for exactly 1 cycle per accepted byte.
- Back-to-back `byte_rdy_in` on consecutive cycles is supported at full rate, one byte per cycle.
- `byte_rdy_in` low: no state change, strobes low.
- Reset asserted mid-pixel: everything returns immediately (asynchronously) to its reset value. The partial pixel is dropped.
- COMMIT and an error detected by the same byte cannot coincide, because each byte is a single event.

## Structure
- Shared package `ws2812_pkg`:
  - opcode constants (`CMD_SET_CHAN` … `CMD_COMMIT`);
  - state enum `stream_state_t`;
  - pixel-mode enum (`MODE_RGB`, `MODE_RGBW`).
- Single module. The opcode decode is factored into the combinational sub-module `ws2812_cmd_dec`: byte in → `stream_state_t` next-state and an unknown flag.

## Test plan
- Reset, then 0x2C followed by 6 data bytes in RGB mode:
  - writes go to channel 0 (`wr_en_out`=0x01);
  - addresses are 0,0,0,1,1,1;
  - `byte_en_out` is 1,2,4,1,2,4.
- 0x2D, 0x01, then 0x2C and 4 bytes: lanes 1,2,4,8 at address 0; `rgbw_mode_out`=1.
- CHANNELS=8, PIXELS=4: 0x2A,0x07 then 0x2C and 12 RGB bytes. The last write is channel 7, address 3. A 13th byte goes to channel 0 (`wr_en_out`=0x01), address 0, lane 1.
- 0x2E and 3 bytes: `wr_en_out`=0xFF on all three. Two more pixels at PIXELS=2 wrap the address to 0 with the channel unchanged.
- 0x2A,0x08 (CHANNELS=8), then 0x55 with `dc_in`=0:
  - `err_out`=1 one cycle after each and stays high;
  - the channel is unchanged;
  - a following 0x2F pulses `frame_rdy_out` for 1 cycle and clears `err_out`.
- `rst_in` pulsed between lane 1 and lane 2 of a pixel: outputs clear immediately. 0x2C plus 3 bytes after release write address 0, lanes 1,2,4.
